grf_dump_reader: RTL and testbench



---
 rtl/cpu_pkg.sv | 21 ++
 rtl/grf_dump_reader.sv | 175 +++++++++++++++++
 tb/tb_grf_dump_reader.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg - shared CPU definitions used by the GRF and its debug readers.
//
// Contents:
//   GRF_ADDR_W / GRF_DATA_W : general register file address and data widths
//   dump_state_e            : state encoding of the GRF dump reader FSM
//                             (DUMP_CSUM is only reachable when the dump
//                             reader is built with GRF_DUMP_CSUM_EN)
package cpu_pkg;

  localparam int GRF_ADDR_W = 5;
  localparam int GRF_DATA_W = 32;

  typedef enum logic [2:0] {
    DUMP_IDLE  = 3'd0,
    DUMP_FETCH = 3'd1,
    DUMP_SEND  = 3'd2,
    DUMP_DONE  = 3'd3,
    DUMP_CSUM  = 3'd4
  } dump_state_e;

endpackage

// File: rtl/grf_dump_reader.sv
// grf_dump_reader - debug read-out engine for the general register file.
//
// On a start pulse the engine walks registers FIRST_REG..LAST_REG through a
// dedicated GRF read port, snapshots each value and streams it out as one
// word per valid/ready transfer.
//
// Ports:
//   clk       : system clock, rising edge
//   reset     : synchronous, active-high reset
//   start     : one-cycle dump request, only honoured in IDLE
//   busy      : high while a dump is in progress (FETCH/SEND/CSUM/DONE)
//   rd_addr   : GRF read port address
//   rd_data   : combinational GRF read data (includes write bypass)
//   out_valid : stream word valid
//   out_ready : stream sink ready
//   out_data  : register value (or checksum word)
//   out_index : register index of out_data
//   out_last  : marks the final word of the dump
//   done      : one-cycle pulse after the final transfer
//
// Optional build macro GRF_DUMP_CSUM_EN: appends one checksum word (XOR of
// all dumped register words, index 0) after the last register word.
module grf_dump_reader
  import cpu_pkg::*;
#(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic [GRF_ADDR_W-1:0] rd_addr,
  input  logic [GRF_DATA_W-1:0] rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [GRF_DATA_W-1:0] out_data,
  output logic [GRF_ADDR_W-1:0] out_index,
  output logic                  out_last,
  output logic                  done
);

  localparam logic [GRF_ADDR_W-1:0] FIRST_IDX = GRF_ADDR_W'(FIRST_REG);
  localparam logic [GRF_ADDR_W-1:0] LAST_IDX  = GRF_ADDR_W'(LAST_REG);

  dump_state_e           state_q, state_d;
  logic [GRF_ADDR_W-1:0] idx_q, idx_d;
  logic                  out_valid_q, out_valid_d;
  logic [GRF_DATA_W-1:0] out_data_q, out_data_d;
  logic [GRF_ADDR_W-1:0] out_index_q, out_index_d;
  logic                  out_last_q, out_last_d;
`ifdef GRF_DUMP_CSUM_EN
  logic [GRF_DATA_W-1:0] csum_q, csum_d;
`endif

  logic xfer;
  logic at_last;

  assign xfer    = out_valid_q && out_ready;
  assign at_last = (idx_q == LAST_IDX);

  // The read port is driven straight from the walk counter; outside FETCH the
  // address simply holds whatever idx last was, which the GRF ignores.
  assign rd_addr   = idx_q;
  assign busy      = (state_q != DUMP_IDLE);
  assign done      = (state_q == DUMP_DONE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign out_last  = out_last_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    out_last_d  = out_last_q;
`ifdef GRF_DUMP_CSUM_EN
    csum_d      = csum_q;
`endif

    case (state_q)
      DUMP_IDLE: begin
        if (start) begin
          idx_d   = FIRST_IDX;
          state_d = DUMP_FETCH;
`ifdef GRF_DUMP_CSUM_EN
          csum_d  = '0;
`endif
        end
      end

      // Snapshot the register in this single cycle so a same-cycle GRF write
      // (visible through the bypass) is what gets reported.
      DUMP_FETCH: begin
        out_data_d  = rd_data;
        out_index_d = idx_q;
        out_valid_d = 1'b1;
`ifdef GRF_DUMP_CSUM_EN
        out_last_d  = 1'b0;
        csum_d      = csum_q ^ rd_data;
`else
        out_last_d  = at_last;
`endif
        state_d     = DUMP_SEND;
      end

      DUMP_SEND: begin
        if (xfer) begin
          if (!at_last) begin
            out_valid_d = 1'b0;
            idx_d       = idx_q + GRF_ADDR_W'(1);
            state_d     = DUMP_FETCH;
          end else begin
`ifdef GRF_DUMP_CSUM_EN
            // Checksum word follows directly; csum_q already folds in the
            // last register because it updated at that FETCH edge.
            out_valid_d = 1'b1;
            out_data_d  = csum_q;
            out_index_d = '0;
            out_last_d  = 1'b1;
            state_d     = DUMP_CSUM;
`else
            out_valid_d = 1'b0;
            state_d     = DUMP_DONE;
`endif
          end
        end
      end

`ifdef GRF_DUMP_CSUM_EN
      DUMP_CSUM: begin
        if (xfer) begin
          out_valid_d = 1'b0;
          state_d     = DUMP_DONE;
        end
      end
`endif

      DUMP_DONE: begin
        state_d = DUMP_IDLE;
      end

      default: begin
        state_d = DUMP_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= DUMP_IDLE;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
`ifdef GRF_DUMP_CSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      out_last_q  <= out_last_d;
`ifdef GRF_DUMP_CSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_grf_dump_reader.sv
`timescale 1ns/1ps
// Testbench for grf_dump_reader. Three instances cover the full range
// (0..31), a short range (8..10) and the checksum range (1..3). A small GRF
// model with two write ports and same-cycle bypass feeds all of them.
module tb_grf_dump_reader;

  typedef struct {
    int          inst;
    logic [4:0]  index;
    logic [31:0] data;
    logic        last;
  } word_t;

  logic        clk;
  logic        reset;
  logic        start_s [3];
  logic        ready_s [3];
  logic        busy_s  [3];
  logic [4:0]  addr_s  [3];
  logic [31:0] rdat_s  [3];
  logic        valid_s [3];
  logic [31:0] data_s  [3];
  logic [4:0]  index_s [3];
  logic        last_s  [3];
  logic        done_s  [3];

  logic [31:0] grf_mem [32];
  logic        wa_en, wb_en;
  logic [4:0]  wa_addr, wb_addr;
  logic [31:0] wa_data, wb_data;
  logic        preload_en;
  int          preload_sel;

  word_t exp_q[$];
  word_t log_q[$];
  int    checks;
  int    failures;
  int    done_cnt [3];
  logic        prev_stall [3];
  logic [31:0] prev_data  [3];
  logic [4:0]  prev_index [3];
  logic        prev_last  [3];

  grf_dump_reader #(.FIRST_REG(0), .LAST_REG(31)) dut (
    .clk(clk), .reset(reset), .start(start_s[0]), .busy(busy_s[0]),
    .rd_addr(addr_s[0]), .rd_data(rdat_s[0]), .out_valid(valid_s[0]),
    .out_ready(ready_s[0]), .out_data(data_s[0]), .out_index(index_s[0]),
    .out_last(last_s[0]), .done(done_s[0]));

  grf_dump_reader #(.FIRST_REG(8), .LAST_REG(10)) dut_short (
    .clk(clk), .reset(reset), .start(start_s[1]), .busy(busy_s[1]),
    .rd_addr(addr_s[1]), .rd_data(rdat_s[1]), .out_valid(valid_s[1]),
    .out_ready(ready_s[1]), .out_data(data_s[1]), .out_index(index_s[1]),
    .out_last(last_s[1]), .done(done_s[1]));

  grf_dump_reader #(.FIRST_REG(1), .LAST_REG(3)) dut_csum (
    .clk(clk), .reset(reset), .start(start_s[2]), .busy(busy_s[2]),
    .rd_addr(addr_s[2]), .rd_data(rdat_s[2]), .out_valid(valid_s[2]),
    .out_ready(ready_s[2]), .out_data(data_s[2]), .out_index(index_s[2]),
    .out_last(last_s[2]), .done(done_s[2]));

  // Free-running 10ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register contents for each preload pattern, straight from the test plan.
  function automatic logic [31:0] modelReg(input int sel, input int r);
    if (r == 0) return 32'h0;
    if (sel == 0) return 32'h1000_0000 + r;
    case (r)
      1: return 32'h0000_000F;
      2: return 32'h0000_00F0;
      3: return 32'h0000_00FF;
      default: return 32'h0;
    endcase
  endfunction

  // GRF read ports: $0 reads zero, and a write in the same cycle is bypassed.
  for (genvar k = 0; k < 3; k++) begin : g_rd
    assign rdat_s[k] = (addr_s[k] == 5'd0) ? 32'h0 :
                       (wa_en && wa_addr == addr_s[k]) ? wa_data :
                       (wb_en && wb_addr == addr_s[k]) ? wb_data :
                       grf_mem[addr_s[k]];
  end

  // GRF storage: bulk preload or the two write ports commit on the clock edge.
  always @(posedge clk) begin
    if (preload_en) begin
      for (int r = 0; r < 32; r++) grf_mem[r] <= 32'h1000_0000 + r;
      if (preload_sel != 0)
        for (int r = 1; r < 32; r++) grf_mem[r] <= modelReg(preload_sel, r);
    end else begin
      if (wa_en) grf_mem[wa_addr] <= wa_data;
      if (wb_en) grf_mem[wb_addr] <= wb_data;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Compare process: on each falling edge, every transfer is matched against
  // the model queue, stalled words must stay frozen, and done must only come
  // after the model's words are all consumed.
  always @(negedge clk) begin : cmp
    word_t e;
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        prev_stall[k] = 1'b0;
      end else begin
        if (prev_stall[k]) begin
          checkOutput("hold_valid", 32'(valid_s[k]), 32'h1);
          checkOutput("hold_data", data_s[k], prev_data[k]);
          checkOutput("hold_index", 32'(index_s[k]), 32'(prev_index[k]));
          checkOutput("hold_last", 32'(last_s[k]), 32'(prev_last[k]));
        end
        if (valid_s[k] && ready_s[k]) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_word inst=%0d actual_index=%0d required=none", k, index_s[k]);
          end else begin
            e = exp_q.pop_front();
            checkOutput("word_inst", 32'(k), 32'(e.inst));
            checkOutput("word_index", 32'(index_s[k]), 32'(e.index));
            checkOutput("word_data", data_s[k], e.data);
            checkOutput("word_last", 32'(last_s[k]), 32'(e.last));
          end
          e.inst = k; e.index = index_s[k]; e.data = data_s[k]; e.last = last_s[k];
          log_q.push_back(e);
        end
        if (done_s[k]) begin
          done_cnt[k]++;
          checkOutput("done_after_all_words", 32'(exp_q.size()), 32'h0);
        end
        prev_stall[k] = valid_s[k] && !ready_s[k];
        prev_data[k]  = data_s[k];
        prev_index[k] = index_s[k];
        prev_last[k]  = last_s[k];
      end
    end
  end

  // Model: the words a dump of first..last must produce, with an optional
  // overridden value (a bypassed write) and the checksum word when enabled.
  task automatic buildExpected(input int inst, input int first, input int last, input int sel,
                               input int patch_idx, input logic [31:0] patch_val);
    word_t w;
    logic [31:0] x;
    x = 32'h0;
    for (int r = first; r <= last; r++) begin
      w.inst  = inst;
      w.index = r[4:0];
      w.data  = (r == patch_idx) ? patch_val : modelReg(sel, r);
      w.last  = (r == last);
`ifdef GRF_DUMP_CSUM_EN
      w.last  = 1'b0;
`endif
      x = x ^ w.data;
      exp_q.push_back(w);
    end
`ifdef GRF_DUMP_CSUM_EN
    w.inst = inst; w.index = 5'd0; w.data = x; w.last = 1'b1;
    exp_q.push_back(w);
`endif
  endtask

  task automatic preloadGrf(input int sel);
    @(posedge clk); #1;
    preload_sel = sel;
    preload_en  = 1'b1;
    @(posedge clk); #1;
    preload_en  = 1'b0;
  endtask

  // Runs one dump on an instance. mode 0: ready held high; 1: ready 1,0,0,1;
  // 2: writes $5/$4 in the FETCH cycle of idx 5; 3: start spammed while busy;
  // 4: reset during SEND of idx 12. cyc returns the start-to-done distance.
  task automatic applyStimulus(input int inst, input int mode, output int cyc, output bit got_done);
    got_done = 1'b0;
    @(posedge clk); #1;
    start_s[inst] = 1'b1;
    ready_s[inst] = 1'b1;
    checkOutput("busy_before_start", 32'(busy_s[inst]), 32'h0);
    @(posedge clk); #1;
    cyc = 1;
    start_s[inst] = (mode == 3);
    if (mode == 1) ready_s[inst] = 1'b0;
    while (cyc < 2000) begin
      @(negedge clk);
      if (cyc == 1) checkOutput("busy_after_start", 32'(busy_s[inst]), 32'h1);
      if (done_s[inst]) begin
        got_done = 1'b1;
        start_s[inst] = 1'b0;
        break;
      end
      if (mode == 4 && cyc == 26) begin
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_valid", 32'(valid_s[inst]), 32'h0);
        checkOutput("reset_busy", 32'(busy_s[inst]), 32'h0);
        checkOutput("reset_done", 32'(done_s[inst]), 32'h0);
        checkOutput("reset_last", 32'(last_s[inst]), 32'h0);
        exp_q.delete();
        break;
      end
      @(posedge clk); #1;
      cyc++;
      if (mode == 1) ready_s[inst] = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      if (mode == 2) begin
        wa_en = (cyc == 11); wa_addr = 5'd5; wa_data = 32'hDEAD_BEEF;
        wb_en = (cyc == 11); wb_addr = 5'd4; wb_data = 32'h4444_4444;
      end
      if (mode == 4 && cyc == 26) begin
        ready_s[inst] = 1'b0;
        reset = 1'b1;
      end
    end
    start_s[inst] = 1'b0;
    ready_s[inst] = 1'b1;
    wa_en = 1'b0;
    wb_en = 1'b0;
  endtask

  // Directed test sequence.
  initial begin
    int  cyc;
    bit  got;
    int  n_full;
    int  t_full;
    int  t_short;
`ifdef GRF_DUMP_CSUM_EN
    n_full = 33; t_full = 66; t_short = 8;
`else
    n_full = 32; t_full = 65; t_short = 7;
`endif
    checks = 0; failures = 0;
    reset = 1'b1;
    preload_en = 1'b0; preload_sel = 0;
    wa_en = 1'b0; wb_en = 1'b0; wa_addr = '0; wb_addr = '0; wa_data = '0; wb_data = '0;
    for (int k = 0; k < 3; k++) begin
      start_s[k] = 1'b0; ready_s[k] = 1'b1; done_cnt[k] = 0; prev_stall[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    checkOutput("rst_busy", 32'(busy_s[0]), 32'h0);
    checkOutput("rst_rd_addr", 32'(addr_s[0]), 32'h0);
    checkOutput("rst_valid", 32'(valid_s[0]), 32'h0);
    checkOutput("rst_data", data_s[0], 32'h0);
    checkOutput("rst_index", 32'(index_s[0]), 32'h0);
    checkOutput("rst_last", 32'(last_s[0]), 32'h0);
    checkOutput("rst_done", 32'(done_s[0]), 32'h0);

    $display("[TB] full dump at full rate");
    preloadGrf(0);
    log_q.delete(); done_cnt[0] = 0;
    buildExpected(0, 0, 31, 0, -1, 32'h0);
    applyStimulus(0, 0, cyc, got);
    checkOutput("full_done_seen", 32'(got), 32'h1);
    checkOutput("full_start_to_done", 32'(cyc), 32'(t_full));
    checkOutput("full_word_count", 32'(log_q.size()), 32'(n_full));
    if (log_q.size() == n_full) begin
      checkOutput("full_word0_data", log_q[0].data, 32'h0);
      checkOutput("full_word1_data", log_q[1].data, 32'h1000_0001);
      checkOutput("full_word31_data", log_q[31].data, 32'h1000_001F);
      checkOutput("full_word31_index", 32'(log_q[31].index), 32'd31);
      checkOutput("full_word30_last", 32'(log_q[30].last), 32'h0);
`ifdef GRF_DUMP_CSUM_EN
      checkOutput("full_word31_last", 32'(log_q[31].last), 32'h0);
      checkOutput("full_csum_last", 32'(log_q[32].last), 32'h1);
`else
      checkOutput("full_word31_last", 32'(log_q[31].last), 32'h1);
`endif
    end
    @(negedge clk);
    checkOutput("full_busy_after_done", 32'(busy_s[0]), 32'h0);
    checkOutput("full_done_once", 32'(done_cnt[0]), 32'h1);

    $display("[TB] backpressure 1,0,0,1");
    preloadGrf(0);
    log_q.delete();
    buildExpected(0, 0, 31, 0, -1, 32'h0);
    applyStimulus(0, 1, cyc, got);
    checkOutput("bp_done_seen", 32'(got), 32'h1);
    checkOutput("bp_word_count", 32'(log_q.size()), 32'(n_full));
    checkOutput("bp_model_drained", 32'(exp_q.size()), 32'h0);

    $display("[TB] concurrent GRF write");
    preloadGrf(0);
    log_q.delete();
    buildExpected(0, 0, 31, 0, 5, 32'hDEAD_BEEF);
    applyStimulus(0, 2, cyc, got);
    checkOutput("cw_done_seen", 32'(got), 32'h1);
    if (log_q.size() > 5) begin
      checkOutput("cw_word5_bypass", log_q[5].data, 32'hDEAD_BEEF);
      checkOutput("cw_word4_unchanged", log_q[4].data, 32'h1000_0004);
    end else checkOutput("cw_word_count", 32'(log_q.size()), 32'(n_full));

    $display("[TB] reset mid-dump");
    preloadGrf(0);
    log_q.delete(); done_cnt[0] = 0;
    buildExpected(0, 0, 31, 0, -1, 32'h0);
    applyStimulus(0, 4, cyc, got);
    checkOutput("rmid_words_before_reset", 32'(log_q.size()), 32'd12);
    repeat (3) @(negedge clk);
    checkOutput("rmid_no_done", 32'(done_cnt[0]), 32'h0);
    log_q.delete();
    buildExpected(0, 0, 31, 0, -1, 32'h0);
    applyStimulus(0, 0, cyc, got);
    checkOutput("rmid_redump_done", 32'(got), 32'h1);
    checkOutput("rmid_redump_cycles", 32'(cyc), 32'(t_full));
    if (log_q.size() > 0) checkOutput("rmid_redump_first_index", 32'(log_q[0].index), 32'h0);
    else checkOutput("rmid_redump_count", 32'(log_q.size()), 32'(n_full));

    $display("[TB] short range with start spam");
    preloadGrf(0);
    log_q.delete(); done_cnt[1] = 0;
    buildExpected(1, 8, 10, 0, -1, 32'h0);
    applyStimulus(1, 3, cyc, got);
    checkOutput("short_done_seen", 32'(got), 32'h1);
    checkOutput("short_start_to_done", 32'(cyc), 32'(t_short));
    repeat (5) @(negedge clk);
    checkOutput("short_done_once", 32'(done_cnt[1]), 32'h1);
    checkOutput("short_busy_idle", 32'(busy_s[1]), 32'h0);
    checkOutput("short_word_count", 32'(log_q.size()), 32'(n_full - 29));
    if (log_q.size() >= 3) begin
      checkOutput("short_first_index", 32'(log_q[0].index), 32'd8);
      checkOutput("short_third_index", 32'(log_q[2].index), 32'd10);
    end

    $display("[TB] checksum range 1..3");
    preloadGrf(1);
    log_q.delete();
    buildExpected(2, 1, 3, 1, -1, 32'h0);
    applyStimulus(2, 0, cyc, got);
    checkOutput("cs_done_seen", 32'(got), 32'h1);
    checkOutput("cs_word_count", 32'(log_q.size()), 32'(n_full - 29));
    if (log_q.size() >= 3) begin
      checkOutput("cs_word3_data", log_q[2].data, 32'h0000_00FF);
`ifdef GRF_DUMP_CSUM_EN
      checkOutput("cs_word3_last", 32'(log_q[2].last), 32'h0);
      if (log_q.size() == 4) begin
        checkOutput("cs_csum_data", log_q[3].data, 32'h0);
        checkOutput("cs_csum_index", 32'(log_q[3].index), 32'h0);
        checkOutput("cs_csum_last", 32'(log_q[3].last), 32'h1);
      end
`else
      checkOutput("cs_word3_last", 32'(log_q[2].last), 32'h1);
`endif
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
